// File: rtl/mismatch_tally_if.sv
// Sample/control and statistics bundle for mismatch_tally.
// The master side drives samples and control pulses; the slave side is the tally.
interface mismatch_tally_if #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
);
  logic             start;
  logic             stop;
  logic             sample_en;
  logic [WIDTH-1:0] ref_val;
  logic [WIDTH-1:0] dut_val;

  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] samples;
  logic [CNT_W-1:0] errors;
  logic [CNT_W-1:0] first_err_idx;
  logic             first_err_valid;
  logic [WIDTH-1:0] err_mask;

  modport master (
    output start, stop, sample_en, ref_val, dut_val,
    input  busy, done, pass, samples, errors, first_err_idx, first_err_valid, err_mask
  );

  modport slave (
    input  start, stop, sample_en, ref_val, dut_val,
    output busy, done, pass, samples, errors, first_err_idx, first_err_valid, err_mask
  );
endinterface

// File: rtl/mismatch_tally.sv
// Reference-vs-DUT comparison stage: counts samples and mismatches over a window
// bounded by start/stop, capturing the first mismatch index and a per-bit error mask.
//
//   state   | meaning
//   IDLE    | after reset, waiting for start
//   RUN     | window open, qualified samples are compared and counted
//   DONE    | window closed, statistics frozen, pass valid
module mismatch_tally #(
  parameter int WIDTH = 1,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              areset,
  mismatch_tally_if.slave   tif
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q, state_d;
  logic [CNT_W-1:0] samples_q, samples_d;
  logic [CNT_W-1:0] errors_q, errors_d;
  logic [CNT_W-1:0] first_idx_q, first_idx_d;
  logic             first_valid_q, first_valid_d;
  logic [WIDTH-1:0] mask_q, mask_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;

  logic [WIDTH-1:0] diff;
  logic             mismatch;
  logic             samples_sat;
  logic             errors_sat;
  logic             clear;

  assign diff        = tif.ref_val ^ tif.dut_val;
  assign mismatch    = |diff;
  assign samples_sat = (samples_q == CNT_MAX);
  assign errors_sat  = (errors_q == CNT_MAX);

  always_comb begin
    state_d       = state_q;
    samples_d     = samples_q;
    errors_d      = errors_q;
    first_idx_d   = first_idx_q;
    first_valid_d = first_valid_q;
    mask_d        = mask_q;
    clear         = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (tif.start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end

      ST_RUN: begin
        // start has priority: the whole window restarts and any sample this cycle is dropped
        if (tif.start) begin
          clear = 1'b1;
        end else begin
          if (tif.sample_en) begin
            if (!samples_sat) begin
              samples_d = samples_q + CNT_ONE;
            end
            if (mismatch) begin
              if (!errors_sat) begin
                errors_d = errors_q + CNT_ONE;
              end
              mask_d = mask_q | diff;
              // index is only meaningful while samples has not saturated
              if (!first_valid_q && !samples_sat) begin
                first_idx_d   = samples_q;
                first_valid_d = 1'b1;
              end
            end
          end
          if (tif.stop) begin
            state_d = ST_DONE;
          end
        end
      end

      ST_DONE: begin
        if (tif.start) begin
          state_d = ST_RUN;
          clear   = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (clear) begin
      samples_d     = '0;
      errors_d      = '0;
      first_idx_d   = '0;
      first_valid_d = 1'b0;
      mask_d        = '0;
    end

    busy_d = (state_d == ST_RUN);
    done_d = (state_d == ST_DONE);
    pass_d = done_d && (errors_d == '0);
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_q       <= ST_IDLE;
      samples_q     <= '0;
      errors_q      <= '0;
      first_idx_q   <= '0;
      first_valid_q <= 1'b0;
      mask_q        <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      pass_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      samples_q     <= samples_d;
      errors_q      <= errors_d;
      first_idx_q   <= first_idx_d;
      first_valid_q <= first_valid_d;
      mask_q        <= mask_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      pass_q        <= pass_d;
    end
  end

  assign tif.busy            = busy_q;
  assign tif.done            = done_q;
  assign tif.pass            = pass_q;
  assign tif.samples         = samples_q;
  assign tif.errors          = errors_q;
  assign tif.first_err_idx   = first_idx_q;
  assign tif.first_err_valid = first_valid_q;
  assign tif.err_mask        = mask_q;

endmodule

// File: doc/mismatch_tally.md
# mismatch_tally

Synthesizable comparison and statistics stage that consumes paired reference/DUT output samples and accumulates pass/fail statistics over a bounded test window. It sits directly downstream of the block under test and its golden model. It replaces ad-hoc per-edge error counting with a registered sample counter, a mismatch counter, the first-mismatch index and a per-bit error mask. Results are presented to the host or bench through a done/pass flag pair.

## Interface
- WIDTH, 1 — number of output bits compared per sample
- CNT_W, 16 — width of all counters and the index register
- clk  in  1  single clock; all state updates on the rising edge
- areset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; clears statistics and opens the window
- stop  in  1  one-cycle pulse; closes the window
- sample_en  in  1  qualifies ref_val/dut_val as one sample this cycle
- ref_val  in  WIDTH  golden-model output
- dut_val  in  WIDTH  block-under-test output
- busy  out  1  window open (RUN state)
- done  out  1  window closed, results stable
- pass  out  1  done and zero mismatches
- samples  out  CNT_W  samples counted in window
- errors  out  CNT_W  samples with any differing bit
- first_err_idx  out  CNT_W  0-based index of the first mismatching sample
- first_err_valid  out  1  first_err_idx holds a captured value
- err_mask  out  WIDTH  OR of (ref_val ^ dut_val) over all counted samples

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset enters IDLE.
- **IDLE:** start moves to RUN. All other inputs are ignored.
- **RUN:** busy=1. Each cycle with sample_en=1:
  - samples increments.
  - mismatch = |(ref_val ^ dut_val). On a mismatch, errors increments and err_mask |= ref_val ^ dut_val.
  - On the first mismatch (first_err_valid=0), first_err_idx takes the pre-increment value of samples and first_err_valid is set.
- stop in RUN moves to DONE. A sample presented in the same cycle as stop is still counted.
- **DONE:** done=1 and pass=(errors==0). All statistics are frozen and sample_en is ignored. start clears the statistics and re-enters RUN.
- start in RUN restarts the window: statistics are cleared and the state stays RUN. A sample presented in that cycle is discarded.
- start and stop asserted together: start wins in every state.
- Counters saturate at 2^CNT_W−1 and do not wrap. Once samples saturates, no further first_err_idx capture occurs.
- A comparison involving X/Z inputs is not defined; the block compares 0/1 values only.

## Timing
- All outputs are registered and update one cycle after the causing edge. A sample presented in cycle n is reflected in samples/errors in cycle n+1.
- Reset values: busy=0, done=0, pass=0, samples=0, errors=0, first_err_idx=0, first_err_valid=0, err_mask=0.
- areset mid-window discards all statistics immediately (asynchronously) and returns to IDLE. After release, a fresh start is required.
- The clearing on start takes effect in the cycle after the pulse, so busy=1 and samples=0 appear together.
- done rises one cycle after stop and stays high until the next start or reset. pass is valid whenever done=1 and is 0 otherwise.

## Test plan
- **Reset/idle:** assert areset mid-RUN with samples=5. All outputs read 0 asynchronously. After release, sample_en pulses without start leave samples=0.
- **Clean window:** WIDTH=1. start, then 100 samples with ref_val=dut_val, then stop → samples=100, errors=0, first_err_valid=0, done=1, pass=1.
- **Mismatch capture:** WIDTH=4. 10 samples; samples 3 and 7 differ by ref^dut=4'b0010 and 4'b1000 → errors=2, first_err_idx=3, err_mask=4'b1010, pass=0.
- **Simultaneous events:**
  - A mismatching sample in the stop cycle is counted (errors=1).
  - start+stop together in RUN restarts the window: samples=0, busy=1, done=0.
- **Saturation:** CNT_W=4. 20 samples, all mismatching → samples=15, errors=15, first_err_idx=0.
- **Restart from DONE:** after a failing window, start, then 4 clean samples, then stop → samples=4, errors=0, err_mask=0, pass=1.
